// File: rtl/rom_window_fetch_if.sv
// ---------------------------------------------------------------------------
// rom_window_fetch_if
// Request and pixel-group handshake bundle between the Bicubic fetch stage
// and its neighbours.
//
// Handshake rules (both channels):
//   A transfer happens on a rising CLK edge where valid and ready are both 1.
//   The producer holds valid and its payload stable until that edge.
//   The consumer may change ready at any time.
//   The payload is ignored while valid is 0.
//
// Signals
//   req_valid / req_ready   request channel (producer = master)
//   req_x, req_y            signed centre column / row of the request
//   out_valid / out_ready   pixel-group channel (producer = slave)
//   out_pix                 {p3,p2,p1,p0}, p0 = column x-1 in bits [7:0]
// ---------------------------------------------------------------------------
interface rom_window_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_x;
    logic [7:0]  req_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pix;

    modport slave (
        input  req_valid, req_x, req_y, out_ready,
        output req_ready, out_valid, out_pix
    );

    modport master (
        output req_valid, req_x, req_y, out_ready,
        input  req_ready, out_valid, out_pix
    );
endinterface

// File: rtl/rom_window_fetch.sv
// ---------------------------------------------------------------------------
// rom_window_fetch
// Fetch stage between ImgROM and the cubic dot calculator. For each request
// (x, y) it reads the four pixels at columns x-1..x+2 of row y, with all
// coordinates clamped into the image, and hands them out as one 32-bit group.
// A single-entry window cache lets a one-column step along a row reuse three
// pixels (one ROM read) and an identical request reuse all four (no read).
//
// Ports
//   CLK, RST      clock; asynchronous active-high reset
//   FLUSH         one-cycle pulse, invalidates the window cache
//   bus           request / pixel-group handshakes (slave side)
//   ROM_CEN       ImgROM chip enable, active-low, low only with a tap address
//   ROM_A         ImgROM address (registered)
//   ROM_Q         ImgROM data, valid the cycle after the address
//   o_dbg_state   current FSM state
// ---------------------------------------------------------------------------
module rom_window_fetch #(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100,
    parameter int AW    = 14
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 FLUSH,
    rom_window_fetch_if.slave    bus,
    output logic                 ROM_CEN,
    output logic [AW-1:0]        ROM_A,
    input  logic [7:0]           ROM_Q,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic signed [9:0] COL_MAX = 10'(IMG_W - 1);
    localparam logic signed [9:0] ROW_MAX = 10'(IMG_H - 1);
    localparam logic [AW-1:0]     IMG_W_A = AW'(IMG_W);

    state_t r_state;
    state_t w_next_state;

    // ROM port and capture pipeline
    logic          r_cen;
    logic [AW-1:0] r_rom_a;
    logic [1:0]    r_tap;       // tap index presented on ROM_A this cycle
    logic          r_q_pend;    // ROM_Q this cycle belongs to tap r_q_idx
    logic [1:0]    r_q_idx;

    // Current window; after delivery it doubles as the cache contents
    logic [7:0]    r_pix     [4];
    logic [7:0]    r_cur_row;
    logic [7:0]    r_cur_col [4];
    logic [AW-1:0] r_row_base;
    logic          r_cache_valid;
    logic          r_fill_ok;   // no FLUSH seen since accept

    // Request decode
    logic signed [9:0] w_sx;
    logic signed [9:0] w_sy;
    logic [7:0]        w_r;
    logic [7:0]        w_c [4];
    logic [AW-1:0]     w_row_base;
    logic              w_same_row;
    logic              w_repeat;
    logic              w_shift;
    logic              w_accept;
    logic              w_deliver;
    logic              w_req_ready;
    logic              w_out_valid;

    function automatic logic [7:0] clamp_idx(input logic signed [9:0] v,
                                             input logic signed [9:0] lim);
        if (v < 10'sd0) begin
            return 8'd0;
        end else if (v > lim) begin
            return lim[7:0];
        end else begin
            return v[7:0];
        end
    endfunction

    // Clamped coordinates and hit classification of the presented request
    always_comb begin
        w_sx       = {{2{bus.req_x[7]}}, bus.req_x};
        w_sy       = {{2{bus.req_y[7]}}, bus.req_y};
        w_r        = clamp_idx(w_sy, ROW_MAX);
        w_c[0]     = clamp_idx(w_sx - 10'sd1, COL_MAX);
        w_c[1]     = clamp_idx(w_sx, COL_MAX);
        w_c[2]     = clamp_idx(w_sx + 10'sd1, COL_MAX);
        w_c[3]     = clamp_idx(w_sx + 10'sd2, COL_MAX);
        w_row_base = AW'(w_r) * IMG_W_A;
        // A request arriving together with FLUSH never hits.
        w_same_row = r_cache_valid && !FLUSH && (w_r == r_cur_row);
        w_repeat   = w_same_row &&
                     (w_c[0] == r_cur_col[0]) && (w_c[1] == r_cur_col[1]) &&
                     (w_c[2] == r_cur_col[2]) && (w_c[3] == r_cur_col[3]);
        w_shift    = w_same_row && !w_repeat &&
                     (w_c[0] == r_cur_col[1]) && (w_c[1] == r_cur_col[2]) &&
                     (w_c[2] == r_cur_col[3]);
    end

    // FSM: next state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = !RST;
                if (bus.req_valid && !RST) begin
                    w_next_state = w_repeat ? S_OUT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_tap == 2'd3) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next_state = S_OUT;
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        w_accept  = w_req_ready && bus.req_valid;
        w_deliver = w_out_valid && bus.out_ready;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cen         <= 1'b1;
            r_rom_a       <= '0;
            r_tap         <= 2'd0;
            r_q_pend      <= 1'b0;
            r_q_idx       <= 2'd0;
            r_cur_row     <= 8'd0;
            r_row_base    <= '0;
            r_cache_valid <= 1'b0;
            r_fill_ok     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_pix[i]     <= 8'd0;
                r_cur_col[i] <= 8'd0;
            end
        end else begin
            // ROM data for the tap issued last cycle lands in its slot now.
            r_q_pend <= !r_cen;
            r_q_idx  <= r_tap;
            if (r_q_pend) begin
                r_pix[r_q_idx] <= ROM_Q;
            end

            if (w_accept) begin
                r_cur_row  <= w_r;
                r_row_base <= w_row_base;
                for (int i = 0; i < 4; i++) begin
                    r_cur_col[i] <= w_c[i];
                end
                if (w_shift) begin
                    // Slide the old window left; only the new p3 is read.
                    r_pix[0] <= r_pix[1];
                    r_pix[1] <= r_pix[2];
                    r_pix[2] <= r_pix[3];
                    r_tap    <= 2'd3;
                    r_cen    <= 1'b0;
                    r_rom_a  <= w_row_base + AW'(w_c[3]);
                end else if (!w_repeat) begin
                    r_tap    <= 2'd0;
                    r_cen    <= 1'b0;
                    r_rom_a  <= w_row_base + AW'(w_c[0]);
                end
            end else if (r_state == S_FETCH) begin
                if (r_tap == 2'd3) begin
                    r_cen <= 1'b1;
                end else begin
                    r_tap   <= r_tap + 2'd1;
                    r_rom_a <= r_row_base + AW'(r_cur_col[r_tap + 2'd1]);
                end
            end

            // The cache is only trusted if nothing flushed it while in flight.
            if (w_accept) begin
                r_fill_ok <= !FLUSH;
            end else if (FLUSH) begin
                r_fill_ok <= 1'b0;
            end

            if (w_deliver) begin
                r_cache_valid <= r_fill_ok && !FLUSH;
            end else if (w_accept || FLUSH) begin
                r_cache_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pix   = {r_pix[3], r_pix[2], r_pix[1], r_pix[0]};
    assign ROM_CEN       = r_cen;
    assign ROM_A         = r_rom_a;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rom_window_fetch.sv
// ---------------------------------------------------------------------------
// tb_rom_window_fetch
// Bench for rom_window_fetch: a directed sequence for the documented corner
// cases, then randomized row sweeps with random backpressure and FLUSH.
// A transaction-level model predicts addresses, timing and pixel data from
// the clamping and cache rules; a negedge process compares every cycle.
// ---------------------------------------------------------------------------
module tb_rom_window_fetch;
    localparam int IMG_W = 100;
    localparam int IMG_H = 100;
    localparam int AW    = 14;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          FLUSH = 1'b0;
    logic          ROM_CEN;
    logic [AW-1:0] ROM_A;
    logic [7:0]    ROM_Q = 8'd0;
    logic [1:0]    dbg_state;
    logic [7:0]    rom_key = 8'd0;
    bit            rand_flush = 1'b0;

    rom_window_fetch_if bus ();

    rom_window_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .FLUSH       (FLUSH),
        .bus         (bus),
        .ROM_CEN     (ROM_CEN),
        .ROM_A       (ROM_A),
        .ROM_Q       (ROM_Q),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- ImgROM model ----------------
    function automatic logic [7:0] rom_val(input logic [AW-1:0] a);
        return a[7:0] ^ rom_key;
    endfunction

    always @(posedge CLK) begin
        if (!ROM_CEN) ROM_Q <= rom_val(ROM_A);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_q[$];

    bit m_cache_valid = 1'b0;
    int m_row;
    int m_col[4];
    bit busy = 1'b0;
    bit fill_ok = 1'b0;
    int k;
    int ov_cyc;
    int n_reads_exp;
    int cur_row;
    int cur_col[4];

    int            dut_reads;
    int            dut_first_ov;
    logic [AW-1:0] dut_addrs[4];
    int            last_lat;
    int            last_reads;
    logic [AW-1:0] last_addrs[4];
    logic [31:0]   last_pix;
    int            ov_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int r, input int c);
        return AW'(r * IMG_W + c);
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge CLK) begin
        bit exp_cen_low;
        bit exp_ov;
        if (RST) begin
            check("rst_req_ready", {31'd0, bus.req_ready}, 0);
            check("rst_rom_cen",   {31'd0, ROM_CEN}, 1);
            check("rst_rom_a",     32'(ROM_A), 0);
            check("rst_out_valid", {31'd0, bus.out_valid}, 0);
            check("rst_out_pix",   bus.out_pix, 0);
            busy = 1'b0;
            m_cache_valid = 1'b0;
            exp_addr_q.delete();
            exp_q.delete();
        end else begin
            if (busy) k++;
            exp_cen_low = busy && k >= 1 && k <= n_reads_exp;
            exp_ov      = busy && k >= ov_cyc;
            check("req_ready", {31'd0, bus.req_ready}, {31'd0, !busy});
            check("rom_cen",   {31'd0, ROM_CEN}, {31'd0, !exp_cen_low});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
            if (bus.out_valid) ov_cycles++;
            if (busy && !ROM_CEN) begin
                if (dut_reads < 4) dut_addrs[dut_reads] = ROM_A;
                dut_reads++;
            end
            if (busy && bus.out_valid && dut_first_ov < 0) dut_first_ov = k;
            if (exp_cen_low) begin
                if (exp_addr_q.size() == 0) check("addr_q_underflow", 1, 0);
                else check("rom_addr", 32'(ROM_A), 32'(exp_addr_q.pop_front()));
            end
            if (exp_ov) check("out_pix", bus.out_pix, exp_q[0]);

            if (exp_ov && bus.out_ready) begin
                void'(exp_q.pop_front());
                busy          = 1'b0;
                last_lat      = dut_first_ov;
                last_reads    = dut_reads;
                last_addrs    = dut_addrs;
                last_pix      = bus.out_pix;
                m_cache_valid = fill_ok;
                m_row         = cur_row;
                m_col         = cur_col;
            end else if (!busy && bus.req_valid) begin
                int  r;
                int  c[4];
                bit  same;
                bit  rep;
                bit  sh;
                r = clampi(int'($signed(bus.req_y)), IMG_H - 1);
                for (int i = 0; i < 4; i++)
                    c[i] = clampi(int'($signed(bus.req_x)) - 1 + i, IMG_W - 1);
                same = m_cache_valid && !FLUSH && (m_row == r);
                rep  = same && c[0] == m_col[0] && c[1] == m_col[1] &&
                       c[2] == m_col[2] && c[3] == m_col[3];
                sh   = same && !rep && c[0] == m_col[1] && c[1] == m_col[2] &&
                       c[2] == m_col[3];
                exp_q.push_back({rom_val(addr_of(r, c[3])), rom_val(addr_of(r, c[2])),
                                 rom_val(addr_of(r, c[1])), rom_val(addr_of(r, c[0]))});
                if (rep) begin
                    n_reads_exp = 0;
                    ov_cyc = 1;
                end else if (sh) begin
                    n_reads_exp = 1;
                    ov_cyc = 3;
                    exp_addr_q.push_back(addr_of(r, c[3]));
                end else begin
                    n_reads_exp = 4;
                    ov_cyc = 6;
                    for (int i = 0; i < 4; i++) exp_addr_q.push_back(addr_of(r, c[i]));
                end
                busy = 1'b1;
                k = 0;
                fill_ok = 1'b1;
                cur_row = r;
                cur_col = c;
                dut_reads = 0;
                dut_first_ov = -1;
            end
            if (FLUSH) begin
                m_cache_valid = 1'b0;
                fill_ok = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
        FLUSH = rand_flush ? ($urandom_range(0, 15) == 0) : 1'b0;
    endtask

    task automatic flush_pulse();
        FLUSH = 1'b1;
        tick();
    endtask

    task automatic do_req(input int x, input int y, input int hold);
        int n;
        bus.req_x     = 8'(x);
        bus.req_y     = 8'(y);
        bus.req_valid = 1'b1;
        bus.out_ready = (hold == 0);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("req_ready_timeout", 0, 1);
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            check("out_valid_timeout", 0, 1);
            bus.out_ready = 1'b1;
            return;
        end
        repeat (hold) tick();
        bus.out_ready = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ov_before;
        int px;
        int py;
        int mode;
        bus.req_valid = 1'b0;
        bus.req_x     = 8'd0;
        bus.req_y     = 8'd0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // Empty-cache miss
        do_req(10, 5, 0);
        check("t1_lat", 32'(last_lat), 6);
        check("t1_reads", 32'(last_reads), 4);
        check("t1_a0", 32'(last_addrs[0]), 509);
        check("t1_a3", 32'(last_addrs[3]), 512);
        check("t1_pix", last_pix, {8'd0, 8'd255, 8'd254, 8'd253});

        // One-column shift, then an identical repeat
        do_req(11, 5, 0);
        check("t2_lat", 32'(last_lat), 3);
        check("t2_reads", 32'(last_reads), 1);
        check("t2_addr", 32'(last_addrs[0]), 513);
        check("t2_pix", last_pix, {8'd1, 8'd0, 8'd255, 8'd254});
        do_req(11, 5, 0);
        check("t2r_lat", 32'(last_lat), 1);
        check("t2r_reads", 32'(last_reads), 0);
        check("t2r_pix", last_pix, {8'd1, 8'd0, 8'd255, 8'd254});

        // Clamping at the borders
        do_req(0, -1, 0);
        check("t3a_a0", 32'(last_addrs[0]), 0);
        check("t3a_a1", 32'(last_addrs[1]), 0);
        check("t3a_a2", 32'(last_addrs[2]), 1);
        check("t3a_a3", 32'(last_addrs[3]), 2);
        do_req(99, 100, 0);
        check("t3b_a0", 32'(last_addrs[0]), 9998);
        check("t3b_a1", 32'(last_addrs[1]), 9999);
        check("t3b_a3", 32'(last_addrs[3]), 9999);
        do_req(97, 99, 0);
        do_req(98, 99, 0);
        check("t3c_reads", 32'(last_reads), 1);
        check("t3c_addr", 32'(last_addrs[0]), 9999);

        // Backpressure for 5 cycles after out_valid
        ov_before = ov_cycles;
        do_req(50, 50, 5);
        check("t4_lat", 32'(last_lat), 6);
        check("t4_ov_cycles", 32'(ov_cycles - ov_before), 6);
        check("t4_idle_ready", {31'd0, bus.req_ready}, 1);

        // FLUSH between a miss and what would have been a shift
        do_req(10, 5, 0);
        flush_pulse();
        do_req(11, 5, 0);
        check("t5_reads", 32'(last_reads), 4);
        check("t5_lat", 32'(last_lat), 6);
        check("t5_pix", last_pix, {8'd1, 8'd0, 8'd255, 8'd254});

        // Reset during cycle 3 of a miss
        flush_pulse();
        bus.req_x     = 8'd10;
        bus.req_y     = 8'd5;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        ov_before = ov_cycles;
        tick();
        tick();
        RST = 1'b0;
        repeat (8) tick();
        check("t6_no_out_valid", 32'(ov_cycles - ov_before), 0);
        do_req(11, 5, 0);
        check("t6_reads", 32'(last_reads), 4);
        check("t6_pix", last_pix, {8'd1, 8'd0, 8'd255, 8'd254});

        // Randomized sweeps, repeats, jumps, backpressure and FLUSH
        rom_key = 8'($urandom_range(1, 255));
        flush_pulse();
        rand_flush = 1'b1;
        px = 20;
        py = 30;
        for (int n = 0; n < 250; n++) begin
            mode = $urandom_range(0, 9);
            if (mode <= 3 && px < 110) begin
                px = px + 1;
            end else if (mode <= 5) begin
                px = px;
            end else if (mode == 6 && px < 110) begin
                px = px + 1;
                py = $urandom_range(0, 108) - 4;
            end else begin
                px = $urandom_range(0, 115) - 8;
                py = $urandom_range(0, 108) - 4;
            end
            do_req(px, py, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        rand_flush = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
